nnet_core_arbiter: RTL and testbench

Packet-level arbiter that shares one HLS neural-net core between two requester streams. Each requester has its own input and output ports. The arbiter grants the core's input to one requester per whole packet, round-robin. For every granted packet it records the requester ID and the 128-bit CHDR header in an in-order tag FIFO. It then routes each result packet from the core back to the correct requester, with the saved header on `tuser`. It sits between two `nnet_vector_wrapper` instances (requester side) and a single core instance (`m_axis_data_*` / `s_axis_data_*` side).

---
 rtl/nnet_arb_pkg.sv | 19 +
 rtl/nnet_tag_fifo.sv | 60 ++++++
 rtl/nnet_core_arbiter.sv | 161 ++++++++++++++++
 tb/tb_nnet_core_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnet_arb_pkg.sv
// Shared types and constants for the two-requester neural-net core arbiter.
package nnet_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam int HEADER_WIDTH_DEFAULT = 128;

    // Tag = {requester id, CHDR header}; the id occupies the MSB.
    localparam int TAG_WIDTH = HEADER_WIDTH_DEFAULT + 1;

    function automatic int tag_width(input int header_width);
        return header_width + 1;
    endfunction

endpackage

// File: rtl/nnet_tag_fifo.sv
// In-order tag FIFO: one entry per packet granted into the core, popped when
// that packet's result leaves the core.
module nnet_tag_fifo #(
    parameter int WIDTH      = 129,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   occupied
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occupied <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occupied <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occupied <= occupied + 1'b1;
                2'b01:   occupied <= occupied - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (occupied == '0);
    assign full  = occupied[DEPTH_LOG2];

endmodule

// File: rtl/nnet_core_arbiter.sv
// Shares one HLS core between two requesters: whole-packet round-robin on the
// way in, tag-directed routing with the saved header on the way out.
module nnet_core_arbiter
    import nnet_arb_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int HEADER_WIDTH  = 128,
    parameter int INFLIGHT_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [2*WIDTH-1:0]        in0_tdata,
    input  logic [HEADER_WIDTH-1:0]   in0_tuser,
    input  logic                      in0_tlast,
    input  logic                      in0_tvalid,
    output logic                      in0_tready,
    input  logic [2*WIDTH-1:0]        in1_tdata,
    input  logic [HEADER_WIDTH-1:0]   in1_tuser,
    input  logic                      in1_tlast,
    input  logic                      in1_tvalid,
    output logic                      in1_tready,
    output logic [2*WIDTH-1:0]        m_axis_data_tdata,
    output logic                      m_axis_data_tlast,
    output logic                      m_axis_data_tvalid,
    input  logic                      m_axis_data_tready,
    input  logic [2*WIDTH-1:0]        s_axis_data_tdata,
    input  logic                      s_axis_data_tlast,
    input  logic                      s_axis_data_tvalid,
    output logic                      s_axis_data_tready,
    output logic [2*WIDTH-1:0]        out0_tdata,
    output logic [HEADER_WIDTH-1:0]   out0_tuser,
    output logic                      out0_tlast,
    output logic                      out0_tvalid,
    input  logic                      out0_tready,
    output logic [2*WIDTH-1:0]        out1_tdata,
    output logic [HEADER_WIDTH-1:0]   out1_tuser,
    output logic                      out1_tlast,
    output logic                      out1_tvalid,
    input  logic                      out1_tready,
    output logic [INFLIGHT_LOG2:0]    inflight,
    output logic                      err_orphan
);

    localparam int TW = tag_width(HEADER_WIDTH);

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic                    last_grant;
    logic                    last_grant_nxt;
    logic                    grant1;
    logic                    tag_push;
    logic [TW-1:0]           tag_push_data;
    logic                    tag_pop;
    logic [TW-1:0]           tag_head;
    logic                    tag_empty;
    logic                    tag_full;
    logic                    head_id;
    logic [HEADER_WIDTH-1:0] head_hdr;

    nnet_tag_fifo #(
        .WIDTH      (TW),
        .DEPTH_LOG2 (INFLIGHT_LOG2)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (tag_push),
        .push_data (tag_push_data),
        .pop       (tag_pop),
        .head      (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .occupied  (inflight)
    );

    // last_grant resets to 1 so that in0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            err_orphan <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            err_orphan <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (s_axis_data_tvalid && tag_empty) err_orphan <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        state_nxt          = state;
        last_grant_nxt     = last_grant;
        grant1             = 1'b0;
        tag_push           = 1'b0;
        tag_push_data      = '0;
        in0_tready         = 1'b0;
        in1_tready         = 1'b0;
        m_axis_data_tvalid = 1'b0;
        m_axis_data_tdata  = '0;
        m_axis_data_tlast  = 1'b0;
        case (state)
            IDLE: begin
                // Grant uses the registered count: a same-cycle pop cannot free a slot.
                if (!tag_full && (in0_tvalid || in1_tvalid)) begin
                    grant1         = in1_tvalid && (!in0_tvalid || !last_grant);
                    tag_push       = 1'b1;
                    tag_push_data  = grant1 ? {1'b1, in1_tuser} : {1'b0, in0_tuser};
                    state_nxt      = grant1 ? BUSY1 : BUSY0;
                    last_grant_nxt = grant1;
                end
            end
            BUSY0: begin
                m_axis_data_tvalid = in0_tvalid;
                m_axis_data_tdata  = in0_tdata;
                m_axis_data_tlast  = in0_tlast;
                in0_tready         = m_axis_data_tready;
                if (in0_tvalid && m_axis_data_tready && in0_tlast) state_nxt = IDLE;
            end
            BUSY1: begin
                m_axis_data_tvalid = in1_tvalid;
                m_axis_data_tdata  = in1_tdata;
                m_axis_data_tlast  = in1_tlast;
                in1_tready         = m_axis_data_tready;
                if (in1_tvalid && m_axis_data_tready && in1_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign {head_id, head_hdr} = tag_head;

    // With no tag outstanding the core is stalled rather than dropped.
    always_comb begin
        s_axis_data_tready = 1'b0;
        out0_tvalid        = 1'b0;
        out1_tvalid        = 1'b0;
        if (!tag_empty) begin
            if (head_id) begin
                out1_tvalid        = s_axis_data_tvalid;
                s_axis_data_tready = out1_tready;
            end else begin
                out0_tvalid        = s_axis_data_tvalid;
                s_axis_data_tready = out0_tready;
            end
        end
    end

    assign tag_pop    = s_axis_data_tvalid && s_axis_data_tready && s_axis_data_tlast;
    assign out0_tdata = s_axis_data_tdata;
    assign out0_tlast = s_axis_data_tlast;
    assign out0_tuser = head_hdr;
    assign out1_tdata = s_axis_data_tdata;
    assign out1_tlast = s_axis_data_tlast;
    assign out1_tuser = head_hdr;

endmodule

// File: tb/tb_nnet_core_arbiter.sv
// Randomised bench for nnet_core_arbiter: transaction-level model with a
// per-cycle compare, an end-to-end beat scoreboard and directed scenarios.
`timescale 1ns/1ps
module tb_nnet_core_arbiter;

    localparam int WIDTH = 16;
    localparam int HW    = 128;
    localparam int IL2   = 2;
    localparam int DW    = 2 * WIDTH;
    localparam int DEPTH = 1 << IL2;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          first;
        logic [HW-1:0] hdr;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } cbeat_t;

    typedef struct {
        int            id;
        logic [HW-1:0] hdr;
    } tag_t;

    logic clk = 1'b0;
    logic reset, clear;
    logic [DW-1:0] in0_tdata, in1_tdata, m_axis_data_tdata, s_axis_data_tdata, out0_tdata, out1_tdata;
    logic [HW-1:0] in0_tuser, in1_tuser, out0_tuser, out1_tuser;
    logic in0_tlast, in0_tvalid, in0_tready, in1_tlast, in1_tvalid, in1_tready;
    logic m_axis_data_tlast, m_axis_data_tvalid, m_axis_data_tready;
    logic s_axis_data_tlast, s_axis_data_tvalid, s_axis_data_tready;
    logic out0_tlast, out0_tvalid, out0_tready, out1_tlast, out1_tvalid, out1_tready;
    logic [IL2:0] inflight;
    logic err_orphan;

    always #5 clk = ~clk;

    nnet_core_arbiter #(.WIDTH(WIDTH), .HEADER_WIDTH(HW), .INFLIGHT_LOG2(IL2)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in0_tdata(in0_tdata), .in0_tuser(in0_tuser), .in0_tlast(in0_tlast),
        .in0_tvalid(in0_tvalid), .in0_tready(in0_tready),
        .in1_tdata(in1_tdata), .in1_tuser(in1_tuser), .in1_tlast(in1_tlast),
        .in1_tvalid(in1_tvalid), .in1_tready(in1_tready),
        .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tlast(m_axis_data_tlast),
        .m_axis_data_tvalid(m_axis_data_tvalid), .m_axis_data_tready(m_axis_data_tready),
        .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tlast(s_axis_data_tlast),
        .s_axis_data_tvalid(s_axis_data_tvalid), .s_axis_data_tready(s_axis_data_tready),
        .out0_tdata(out0_tdata), .out0_tuser(out0_tuser), .out0_tlast(out0_tlast),
        .out0_tvalid(out0_tvalid), .out0_tready(out0_tready),
        .out1_tdata(out1_tdata), .out1_tuser(out1_tuser), .out1_tlast(out1_tlast),
        .out1_tvalid(out1_tvalid), .out1_tready(out1_tready),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [HW:0] got, input logic [HW:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Stimulus state shared between driver and checker.
    beat_t  src_q[2][$];
    cbeat_t core_q[$];
    cbeat_t sb_q[2][$];
    int     src_rate[2];
    int     out_rate[2];
    int     m_rate, core_rate;
    bit     core_orphan;
    bit     iv[2];
    bit     sv;
    bit     hs_in[2];
    bit     hs_s;
    int     in_acc[2];
    int     grant_log[$];
    logic [HW-1:0] first_out0_user;
    bit     got_out0_user;
    int     out1_seen;

    // Reference model: grant order, outstanding tags and the sticky error.
    int     m_busy;
    int     m_last;
    tag_t   m_tags[$];
    bit     m_err;

    always @(negedge clk) begin : compare
        bit v[2];
        logic [DW-1:0] d[2];
        bit l[2];
        bit e_rdy[2];
        bit e_ov[2];
        bit e_mv, e_sr, gnt, hs_o[2];
        int dst, gid;
        cbeat_t cb;

        hs_in[0] = in0_tvalid && in0_tready;
        hs_in[1] = in1_tvalid && in1_tready;
        hs_s     = s_axis_data_tvalid && s_axis_data_tready;
        hs_o[0]  = out0_tvalid && out0_tready;
        hs_o[1]  = out1_tvalid && out1_tready;
        if (!reset) begin
            m_busy = -1;
            m_last = 1;
            m_tags.delete();
            m_err  = 1'b0;
        end
        v = '{in0_tvalid, in1_tvalid};
        d = '{in0_tdata, in1_tdata};
        l = '{in0_tlast, in1_tlast};
        e_rdy = '{1'b0, 1'b0};
        e_mv  = 1'b0;
        if (m_busy >= 0) begin
            e_mv          = v[m_busy];
            e_rdy[m_busy] = m_axis_data_tready;
        end
        check("in0_tready", in0_tready, e_rdy[0]);
        check("in1_tready", in1_tready, e_rdy[1]);
        check("m_tvalid", m_axis_data_tvalid, e_mv);
        if (e_mv && m_axis_data_tvalid) begin
            check("m_tdata", m_axis_data_tdata, d[m_busy]);
            check("m_tlast", m_axis_data_tlast, l[m_busy]);
        end
        e_ov = '{1'b0, 1'b0};
        e_sr = 1'b0;
        if (m_tags.size() > 0) begin
            dst       = m_tags[0].id;
            e_ov[dst] = s_axis_data_tvalid;
            e_sr      = (dst == 1) ? out1_tready : out0_tready;
        end
        check("out0_tvalid", out0_tvalid, e_ov[0]);
        check("out1_tvalid", out1_tvalid, e_ov[1]);
        check("s_tready", s_axis_data_tready, e_sr);
        if (out0_tvalid && e_ov[0]) check("out0_tuser", out0_tuser, m_tags[0].hdr);
        if (out1_tvalid && e_ov[1]) check("out1_tuser", out1_tuser, m_tags[0].hdr);
        check("inflight", inflight, m_tags.size());
        check("err_orphan", err_orphan, m_err);

        if (reset) begin
            for (int x = 0; x < 2; x++) begin
                if (hs_in[x]) begin
                    sb_q[x].push_back('{d[x], l[x]});
                    in_acc[x]++;
                end
            end
            if (hs_o[0] || hs_o[1]) begin
                dst = hs_o[1] ? 1 : 0;
                check("sb_has_beat", sb_q[dst].size() > 0, 1'b1);
                if (sb_q[dst].size() > 0) begin
                    cb = sb_q[dst].pop_front();
                    check("sb_tdata", dst == 1 ? out1_tdata : out0_tdata, cb.data);
                    check("sb_tlast", dst == 1 ? out1_tlast : out0_tlast, cb.last);
                end
            end
            if (hs_o[0] && !got_out0_user) begin
                first_out0_user = out0_tuser;
                got_out0_user   = 1'b1;
            end
            if (out1_tvalid) out1_seen++;
            if (m_axis_data_tvalid && m_axis_data_tready)
                core_q.push_back('{m_axis_data_tdata, m_axis_data_tlast});

            if (clear) begin
                m_busy = -1;
                m_last = 1;
                m_tags.delete();
                m_err  = 1'b0;
            end else begin
                gnt = 1'b0;
                gid = 0;
                if (m_busy < 0 && m_tags.size() < DEPTH && (v[0] || v[1])) begin
                    gid = (v[0] && v[1]) ? 1 - m_last : (v[0] ? 0 : 1);
                    gnt = 1'b1;
                end else if (m_busy >= 0 && v[m_busy] && m_axis_data_tready && l[m_busy]) begin
                    m_busy = -1;
                end
                if (s_axis_data_tvalid && m_tags.size() == 0) m_err = 1'b1;
                if (s_axis_data_tvalid && e_sr && s_axis_data_tlast) void'(m_tags.pop_front());
                if (gnt) begin
                    m_tags.push_back('{gid, (gid == 1) ? in1_tuser : in0_tuser});
                    m_busy = gid;
                    m_last = gid;
                    grant_log.push_back(gid);
                end
            end
        end
    end

    function automatic logic [HW-1:0] rand_hdr();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_pkt(input int x, input int len, input logic [HW-1:0] hdr);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data  = $urandom();
            b.last  = (i == len - 1);
            b.first = (i == 0);
            b.hdr   = hdr;
            src_q[x].push_back(b);
        end
    endtask

    task automatic drive();
        logic [DW-1:0] dd[2];
        logic          ll[2];
        logic [HW-1:0] uu[2];
        for (int x = 0; x < 2; x++) begin
            if (hs_in[x] && src_q[x].size() > 0) begin
                void'(src_q[x].pop_front());
                iv[x] = 1'b0;
            end
            if (src_q[x].size() == 0) iv[x] = 1'b0;
            else if (!iv[x] && $urandom_range(99) < src_rate[x]) iv[x] = 1'b1;
            dd[x] = iv[x] ? src_q[x][0].data : '0;
            ll[x] = iv[x] ? src_q[x][0].last : 1'b0;
            // Header only on the first beat; later beats carry junk that must be ignored.
            uu[x] = (iv[x] && src_q[x][0].first) ? src_q[x][0].hdr : rand_hdr();
        end
        {in0_tvalid, in0_tdata, in0_tlast, in0_tuser} = {iv[0], dd[0], ll[0], uu[0]};
        {in1_tvalid, in1_tdata, in1_tlast, in1_tuser} = {iv[1], dd[1], ll[1], uu[1]};
        if (hs_s && core_q.size() > 0) begin
            void'(core_q.pop_front());
            sv = 1'b0;
        end
        if (core_q.size() == 0) sv = 1'b0;
        else if (!sv && $urandom_range(99) < core_rate) sv = 1'b1;
        s_axis_data_tvalid = sv || core_orphan;
        s_axis_data_tdata  = sv ? core_q[0].data : $urandom();
        s_axis_data_tlast  = sv ? core_q[0].last : 1'($urandom_range(1));
        m_axis_data_tready = $urandom_range(99) < m_rate;
        out0_tready        = $urandom_range(99) < out_rate[0];
        out1_tready        = $urandom_range(99) < out_rate[1];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic flush();
        src_q[0].delete();
        src_q[1].delete();
        sb_q[0].delete();
        sb_q[1].delete();
        core_q.delete();
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        flush();
        clear = 1'b1;
        drive();
        @(posedge clk);
        #1;
        clear = 1'b0;
        drive();
    endtask

    task automatic set_rates(input int r);
        src_rate  = '{r, r};
        out_rate  = '{r, r};
        m_rate    = r;
        core_rate = r;
    endtask

    task automatic drain(input string name);
        int n = 0;
        set_rates(100);
        while ((src_q[0].size() > 0 || src_q[1].size() > 0 || core_q.size() > 0 || inflight != 0) && n < 1000) begin
            cyc();
            n++;
        end
        cyc();
        check({name, "_drain_in_time"}, n < 1000, 1'b1);
        check({name, "_sb_empty"}, sb_q[0].size() + sb_q[1].size(), 0);
    endtask

    initial begin : watchdog
        #800000;
        failures++;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        int  n;
        bit  found;
        reset = 1'b0;
        clear = 1'b0;
        core_orphan = 1'b0;
        iv = '{1'b0, 1'b0};
        sv = 1'b0;
        set_rates(0);
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in0_tready", in0_tready, 1'b0);
        check("rst_s_tready", s_axis_data_tready, 1'b0);
        check("rst_inflight", inflight, 0);
        check("rst_err", err_orphan, 1'b0);
        #1 reset = 1'b1;

        // Single 8-beat packet from in0, echoed by the core.
        set_rates(100);
        got_out0_user = 1'b0;
        out1_seen     = 0;
        load_pkt(0, 8, {16{8'hA5}});
        cyc();
        @(negedge clk);
        check("sp_idle_tready", in0_tready, 1'b0);
        check("sp_inflight_0", inflight, 0);
        cyc();
        @(negedge clk);
        check("sp_first_beat", in0_tready && in0_tvalid, 1'b1);
        check("sp_inflight_1", inflight, 1);
        drain("sp");
        check("sp_tuser", first_out0_user, {16{8'hA5}});
        check("sp_out1_quiet", out1_seen, 0);
        check("sp_inflight_end", inflight, 0);

        // Contention: both requesters always valid, 4-beat packets.
        do_clear();
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            load_pkt(0, 4, rand_hdr());
            load_pkt(1, 4, rand_hdr());
        end
        drain("ct");
        check("ct_grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < grant_log.size()) check("ct_grant_order", grant_log[i], i % 2);

        // Full FIFO: core withholds output while five packets are offered.
        do_clear();
        set_rates(100);
        core_rate = 0;
        for (int i = 0; i < 5; i++) load_pkt(0, 2, rand_hdr());
        n = 0;
        while (inflight != 4 && n < 100) begin
            cyc();
            n++;
        end
        repeat (3) cyc();
        @(negedge clk);
        check("ff_full", inflight, 4);
        check("ff_stall_tready", in0_tready, 1'b0);
        check("ff_stall_valid", in0_tvalid, 1'b1);
        core_rate = 100;
        n = 0;
        found = 1'b0;
        while (!found && n < 50) begin
            cyc();
            @(negedge clk);
            found = s_axis_data_tvalid && s_axis_data_tready && s_axis_data_tlast;
            n++;
        end
        check("ff_pop_seen", found, 1'b1);
        cyc();
        @(negedge clk);
        check("ff_no_grant_yet", in0_tready, 1'b0);
        check("ff_after_pop", inflight, 3);
        cyc();
        @(negedge clk);
        check("ff_granted", in0_tready, 1'b1);
        check("ff_refilled", inflight, 4);
        drain("ff");

        // Random traffic with random backpressure on every interface.
        do_clear();
        for (int r = 0; r < 4; r++) begin
            src_rate  = '{$urandom_range(100, 30), $urandom_range(100, 30)};
            out_rate  = '{$urandom_range(100, 20), $urandom_range(100, 20)};
            m_rate    = $urandom_range(100, 30);
            core_rate = $urandom_range(100, 30);
            for (int p = 0; p < 12; p++) load_pkt($urandom_range(1), $urandom_range(6, 1), rand_hdr());
            repeat (300) cyc();
            drain("rnd");
        end

        // Orphan core output with nothing outstanding.
        do_clear();
        core_orphan = 1'b1;
        cyc();
        @(negedge clk);
        check("orph_tready", s_axis_data_tready, 1'b0);
        check("orph_not_yet", err_orphan, 1'b0);
        cyc();
        @(negedge clk);
        check("orph_err", err_orphan, 1'b1);
        core_orphan = 1'b0;
        cyc();
        @(negedge clk);
        check("orph_sticky", err_orphan, 1'b1);
        do_clear();
        @(negedge clk);
        check("orph_cleared", err_orphan, 1'b0);

        // Asynchronous reset in the middle of an 8-beat packet.
        set_rates(100);
        core_rate = 0;
        in_acc    = '{0, 0};
        load_pkt(0, 8, rand_hdr());
        n = 0;
        while (in_acc[0] < 3 && n < 50) begin
            cyc();
            n++;
        end
        check("ar_mid_packet", in0_tready && in0_tvalid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("ar_in0_tready", in0_tready, 1'b0);
        check("ar_m_tvalid", m_axis_data_tvalid, 1'b0);
        check("ar_inflight", inflight, 0);
        check("ar_err", err_orphan, 1'b0);
        flush();
        drive();
        repeat (2) cyc();
        #1 reset = 1'b1;
        grant_log.delete();
        load_pkt(0, 3, rand_hdr());
        load_pkt(1, 3, rand_hdr());
        drain("ar");
        check("ar_grants", grant_log.size(), 2);
        if (grant_log.size() > 0) check("ar_first_tie", grant_log[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
